// File: rtl/ccff_prog_ctrl.sv
// ccff_prog_ctrl: configuration-chain programming controller.
//
// Accepts bitstream words over a valid/ready handshake and serialises them
// MSB-first onto the configuration flip-flop chain head. It counts exactly
// CHAIN_LEN bits per pass, keeps a running parity of every bit shifted and
// flags completion.
//
// Ports:
//   prog_clk      in   programming clock, rising edge
//   prog_reset_n  in   asynchronous active-low reset
//   start         in   begin a pass (honoured in IDLE and DONE only)
//   abort         in   cancel the pass; highest priority after reset
//   word_data     in   bitstream word, bit WORD_W-1 shifted first
//   word_valid    in   word_data is valid
//   word_ready    out  word accepted this cycle (gated low by abort)
//   ccff_head     out  serial data to the chain head
//   ccff_shift_en out  chain captures ccff_head at the end of this cycle
//   busy          out  pass in progress (WAIT_WORD or SHIFT)
//   done          out  CHAIN_LEN bits shifted; held until start or abort
//   cfg_parity    out  XOR of all bits shifted in the current/last pass
//   bit_cnt       out  bits shifted so far in this pass
module ccff_prog_ctrl #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_parity,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int unsigned WL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitWord,
    StShift,
    StDone
  } state_e;

  state_e            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [WL_W-1:0]   word_left_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              parity_q;

  logic [CNT_W-1:0]  bits_remaining;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic [WL_W-1:0]   word_left_init;

  assign bits_remaining = CNT_W'(CHAIN_LEN) - bit_cnt_q;
  assign bit_cnt_inc    = bit_cnt_q + CNT_W'(1);

  // A word never shifts past the end of the chain: the final word is
  // truncated to the bits still missing and its low bits are dropped.
  always_comb begin
    word_left_init = WL_W'(WORD_W);
    if (32'(bits_remaining) < WORD_W) begin
      word_left_init = WL_W'(bits_remaining);
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      word_left_q <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
    end else if (abort) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            state_q   <= StWaitWord;
          end
        end
        StWaitWord: begin
          if (word_valid) begin
            sreg_q      <= word_data;
            word_left_q <= word_left_init;
            state_q     <= StShift;
          end
        end
        StShift: begin
          sreg_q      <= sreg_q << 1;
          bit_cnt_q   <= bit_cnt_inc;
          parity_q    <= parity_q ^ sreg_q[WORD_W-1];
          word_left_q <= word_left_q - WL_W'(1);
          if (word_left_q == WL_W'(1)) begin
            state_q <= (bit_cnt_inc == CNT_W'(CHAIN_LEN)) ? StDone : StWaitWord;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from registered state only; abort is the single
  // combinational term, so a word offered alongside abort is refused.
  assign word_ready    = (state_q == StWaitWord) && !abort;
  assign ccff_shift_en = (state_q == StShift);
  assign ccff_head     = (state_q == StShift) && sreg_q[WORD_W-1];
  assign busy          = (state_q == StWaitWord) || (state_q == StShift);
  assign done          = (state_q == StDone);
  assign cfg_parity    = parity_q;
  assign bit_cnt       = bit_cnt_q;

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// Self-checking bench for ccff_prog_ctrl (WORD_W=8, CHAIN_LEN=20).
// Expected head bits are queued when a word is offered and popped by a
// monitor on every shift cycle; status outputs are checked against a small
// parity/count model kept alongside the stimulus.
module tb_ccff_prog_ctrl;

  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CHAIN_LEN = 20;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

  logic              prog_clk = 1'b0;
  logic              prog_reset_n;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              busy;
  logic              done;
  logic              cfg_parity;
  logic [CNT_W-1:0]  bit_cnt;

  ccff_prog_ctrl #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .abort        (abort),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .busy         (busy),
    .done         (done),
    .cfg_parity   (cfg_parity),
    .bit_cnt      (bit_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   shifts      = 0;
  logic head_q[$];
  logic exp_par;
  int   exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one expected head bit per shift cycle.
  always @(negedge prog_clk) begin
    if (prog_reset_n && ccff_shift_en) begin
      shifts++;
      if (head_q.size() == 0) begin
        check("unexpected_shift", 32'(ccff_head), 32'hx);
      end else begin
        check("ccff_head", 32'(ccff_head), 32'(head_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start   = 1'b0;
    shifts  = 0;
    exp_par = 1'b0;
    exp_cnt = 0;
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(word_ready), 1);
    check("start_done", 32'(done), 0);
    check("start_cnt", 32'(bit_cnt), 0);
    check("start_par", 32'(cfg_parity), 0);
  endtask

  // Offer a word and wait for acceptance; n is how many of its top bits
  // should reach the chain. lat = cycles spent waiting for word_ready.
  task automatic send_word(input logic [WORD_W-1:0] w, input int n, output int lat);
    int t = 0;
    word_data  = w;
    word_valid = 1'b1;
    while (!word_ready && t < 100) begin
      tick();
      t++;
    end
    if (!word_ready) check("ready_timeout", 32'(word_ready), 1);
    for (int i = 0; i < n; i++) begin
      head_q.push_back(w[WORD_W-1-i]);
      exp_par ^= w[WORD_W-1-i];
      exp_cnt++;
    end
    tick();
    lat = t;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 50) begin
      tick();
      t++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cnt"}, 32'(bit_cnt), 32'(exp_cnt));
    check({tag, "_cnt20"}, 32'(bit_cnt), CHAIN_LEN);
    check({tag, "_par"}, 32'(cfg_parity), 32'(exp_par));
    check({tag, "_shifts"}, 32'(shifts), CHAIN_LEN);
    check({tag, "_q_empty"}, 32'(head_q.size()), 0);
  endtask

  initial begin
    int lat;
    logic par_hold;
    prog_reset_n = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    word_data    = '0;
    word_valid   = 1'b0;
    #2;
    check("rst_ready", 32'(word_ready), 0);
    check("rst_shift", 32'(ccff_shift_en), 0);
    check("rst_head", 32'(ccff_head), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'(bit_cnt), 0);
    check("rst_par", 32'(cfg_parity), 0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    tick();

    // Basic pass: A5, 3C, F0 (last word truncated to 4 bits).
    do_start();
    send_word(8'hA5, 8, lat);
    send_word(8'h3C, 8, lat);
    check("bubble_w2", 32'(lat), 8);
    send_word(8'hF0, 4, lat);
    check("bubble_w3", 32'(lat), 8);
    wait_done();
    check_end("basic");
    check("basic_par0", 32'(cfg_parity), 0);

    // DONE ignores words and holds status.
    par_hold   = cfg_parity;
    word_data  = 8'hFF;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_ready", 32'(word_ready), 0);
      check("done_shift", 32'(ccff_shift_en), 0);
      check("done_cnt", 32'(bit_cnt), CHAIN_LEN);
      check("done_par", 32'(cfg_parity), 32'(par_hold));
    end
    word_valid = 1'b0;

    // Restart from DONE, then parity / partial-word pass.
    do_start();
    send_word(8'h01, 8, lat);
    send_word(8'h00, 8, lat);
    send_word(8'h0F, 4, lat);
    wait_done();
    check_end("parity");
    check("parity_par1", 32'(cfg_parity), 1);

    // Backpressure: valid low for 5 cycles in WAIT_WORD.
    do_start();
    send_word(8'h5A, 8, lat);
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_ready", 32'(word_ready), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_shift", 32'(ccff_shift_en), 0);
      check("bp_cnt", 32'(bit_cnt), 8);
    end
    send_word(8'hC3, 8, lat);
    check("bp_resume", 32'(ccff_shift_en), 1);
    send_word(8'h96, 4, lat);
    wait_done();
    check_end("bp");

    // Abort on the 3rd shift cycle of word 2.
    do_start();
    send_word(8'hAA, 8, lat);
    send_word(8'h55, 8, lat);
    tick();
    tick();
    check("ab_in_shift", 32'(ccff_shift_en), 1);
    abort = 1'b1;
    check("ab_ready_gate", 32'(word_ready), 0);
    tick();
    abort      = 1'b0;
    word_valid = 1'b0;
    head_q.delete();
    check("ab_shift", 32'(ccff_shift_en), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_cnt", 32'(bit_cnt), 0);
    check("ab_done", 32'(done), 0);
    check("ab_par", 32'(cfg_parity), 0);

    // Abort with a word offered in WAIT_WORD: not accepted.
    do_start();
    word_data  = 8'hFF;
    word_valid = 1'b1;
    abort      = 1'b1;
    #1;
    check("abw_ready_gate", 32'(word_ready), 0);
    tick();
    abort      = 1'b0;
    word_valid = 1'b0;
    check("abw_busy", 32'(busy), 0);
    check("abw_shift", 32'(ccff_shift_en), 0);

    // Normal pass after abort.
    do_start();
    send_word(8'h81, 8, lat);
    send_word(8'h7E, 8, lat);
    send_word(8'hB0, 4, lat);
    wait_done();
    check_end("post_abort");

    // Asynchronous reset during SHIFT.
    do_start();
    send_word(8'hFF, 8, lat);
    tick();
    #2;
    prog_reset_n = 1'b0;
    #1;
    head_q.delete();
    check("arst_ready", 32'(word_ready), 0);
    check("arst_shift", 32'(ccff_shift_en), 0);
    check("arst_head", 32'(ccff_head), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_cnt", 32'(bit_cnt), 0);
    check("arst_par", 32'(cfg_parity), 0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy), 0);
    check("arst_idle_ready", 32'(word_ready), 0);
    do_start();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
